// File: rtl/booth_mult_arbiter.sv
// Round-robin scheduler sharing one sequential booth multiplier among NREQ requesters.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip the multiplier and answer 0 directly.
module booth_mult_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [2*WIDTH-1:0]   rsp_m,
   output logic [IDW-1:0]       grant_id,
   output logic                 busy,
   output logic                 mult_en,
   output logic [WIDTH-1:0]     mult_a,
   output logic [WIDTH-1:0]     mult_b,
   input  logic                 mult_done,
   input  logic [2*WIDTH-1:0]   mult_m
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_r;
   state_t               next_state_s;
   logic [IDW-1:0]       rr_ptr_r;
   logic [IDW-1:0]       grant_id_r;
   logic [WIDTH-1:0]     op_a_r;
   logic [WIDTH-1:0]     op_b_r;
   logic [2*WIDTH-1:0]   rsp_m_r;
   logic [NREQ-1:0]      rsp_valid_r;
   logic                 mult_en_r;
   logic                 busy_r;
   logic                 found_s;
   logic [IDW-1:0]       pick_s;
   logic [IDW-1:0]       ptr_next_s;
   logic [WIDTH-1:0]     sel_a_s;
   logic [WIDTH-1:0]     sel_b_s;
   logic                 bypass_s;
   int                   idx_s;

   function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
      logic [NREQ-1:0] v;
      v = {NREQ{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin scan starting at rr_ptr; first valid requester wins.
   always_comb begin
      found_s = 1'b0;
      pick_s  = {IDW{1'b0}};
      idx_s   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s = (int'(rr_ptr_r) + k) % NREQ;
         if (!found_s && req_valid[idx_s]) begin
            found_s = 1'b1;
            pick_s  = idx_s[IDW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Operand selection for the winner and the pointer value after its grant.
   always_comb begin
      sel_a_s    = req_a[int'(pick_s)*WIDTH +: WIDTH];
      sel_b_s    = req_b[int'(pick_s)*WIDTH +: WIDTH];
      if (pick_s == IDW'(NREQ-1)) begin
         ptr_next_s = {IDW{1'b0}};
      end else begin
         ptr_next_s = pick_s + IDW'(1);
      end
   end

`ifdef MULT_ZERO_BYPASS_EN
   assign bypass_s = found_s && ((sel_a_s == {WIDTH{1'b0}}) || (sel_b_s == {WIDTH{1'b0}}));
`else
   assign bypass_s = 1'b0;
`endif

   // Accept strobe: only in IDLE and never while reset is asserted.
   always_comb begin
      req_ready = {NREQ{1'b0}};
      if (rst_n && (state_r == IDLE) && found_s) begin
         req_ready[pick_s] = 1'b1;
      end else begin
         req_ready = {NREQ{1'b0}};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; mult_done only matters in RUN.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               next_state_s = bypass_s ? RESP : RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (mult_done) begin
               next_state_s = RESP;
            end else begin
               next_state_s = RUN;
            end
         end
         RESP: begin
            if (rsp_ready[grant_id_r]) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RESP;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Registered datapath and outputs; reset drops any transaction in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_r    <= {IDW{1'b0}};
         grant_id_r  <= {IDW{1'b0}};
         op_a_r      <= {WIDTH{1'b0}};
         op_b_r      <= {WIDTH{1'b0}};
         rsp_m_r     <= {2*WIDTH{1'b0}};
         rsp_valid_r <= {NREQ{1'b0}};
         mult_en_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  grant_id_r <= pick_s;
                  rr_ptr_r   <= ptr_next_s;
                  op_a_r     <= sel_a_s;
                  op_b_r     <= sel_b_s;
                  busy_r     <= 1'b1;
                  if (bypass_s) begin
                     rsp_m_r     <= {2*WIDTH{1'b0}};
                     rsp_valid_r <= onehot(pick_s);
                  end else begin
                     mult_en_r <= 1'b1;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            RUN: begin
               if (mult_done) begin
                  rsp_m_r     <= mult_m;
                  mult_en_r   <= 1'b0;
                  rsp_valid_r <= onehot(grant_id_r);
               end else begin
                  mult_en_r <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready[grant_id_r]) begin
                  rsp_valid_r <= {NREQ{1'b0}};
                  busy_r      <= 1'b0;
               end else begin
                  busy_r <= 1'b1;
               end
            end
            default: begin
               rsp_valid_r <= {NREQ{1'b0}};
               mult_en_r   <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_r;
   assign rsp_m     = rsp_m_r;
   assign grant_id  = grant_id_r;
   assign busy      = busy_r;
   assign mult_en   = mult_en_r;
   assign mult_a    = op_a_r;
   assign mult_b    = op_b_r;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a small multi-cycle multiplier responder.
// Build with +define+MULT_ZERO_BYPASS_EN to exercise the zero-operand bypass.
module tb_booth_mult_arbiter;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [31:0]  req_a;
   logic [31:0]  req_b;
   logic [3:0]   rsp_valid;
   logic [3:0]   rsp_ready;
   logic [15:0]  rsp_m;
   logic [1:0]   grant_id;
   logic         busy;
   logic         mult_en;
   logic [7:0]   mult_a;
   logic [7:0]   mult_b;
   logic         mult_done;
   logic [15:0]  mult_m;

   int checks_r = 0;
   int errors_r = 0;
   int multi_hot_r = 0;
   int en_cycles_r = 0;
   logic [1:0] lat_cnt_r;

   booth_mult_arbiter #(.WIDTH(8), .NREQ(4), .IDW(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_m(rsp_m),
      .grant_id(grant_id), .busy(busy),
      .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b),
      .mult_done(mult_done), .mult_m(mult_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier stand-in: done pulses after three enabled cycles.
   always @(posedge clk) begin
      if (!rst_n) begin
         lat_cnt_r <= 2'd0;
         mult_done <= 1'b0;
         mult_m    <= 16'd0;
      end else if (mult_en && !mult_done) begin
         en_cycles_r <= en_cycles_r + 1;
         if (lat_cnt_r == 2'd2) begin
            mult_done <= 1'b1;
            mult_m    <= {{8{mult_a[7]}}, mult_a} * {{8{mult_b[7]}}, mult_b};
            lat_cnt_r <= 2'd0;
         end else begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
         end
      end else begin
         mult_done <= 1'b0;
         lat_cnt_r <= 2'd0;
      end
   end

   // Response and accept strobes must never be multi-hot.
   always @(negedge clk) begin
      if ($countones(rsp_valid) > 1 || $countones(req_ready) > 1) multi_hot_r <= multi_hot_r + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_r++;
      if (got !== exp) begin
         errors_r++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[i*8 +: 8] = a;
      req_b[i*8 +: 8] = b;
      req_valid[i]    = 1'b1;
   endtask

   task automatic wait_grant();
      for (int k = 0; k < 20; k++) begin
         #1;
         if (req_ready != 4'd0) return;
         @(negedge clk);
      end
   endtask

   task automatic wait_rsp();
      for (int k = 0; k < 40; k++) begin
         if (rsp_valid != 4'd0) return;
         @(negedge clk);
      end
   endtask

   task automatic handshake(input int idx);
      rsp_ready[idx] = 1'b1;
      @(negedge clk);
      rsp_ready = 4'd0;
      check("rsp_clear", 32'(rsp_valid), 32'd0);
   endtask

   // Full transaction for requester idx; keep=0 drops all valids after accept.
   task automatic serve(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input int m_exp, input bit keep);
      wait_grant();
      check("grant", 32'(req_ready), 32'd1 << idx);
      @(negedge clk);
      if (!keep) req_valid = 4'd0;
      check("grant_id", 32'(grant_id), 32'(idx));
      check("busy_run", 32'(busy), 32'd1);
      check("mult_en_run", 32'(mult_en), 32'd1);
      check("mult_a", 32'(mult_a), 32'(a));
      check("mult_b", 32'(mult_b), 32'(b));
      wait_rsp();
      check("rsp_valid", 32'(rsp_valid), 32'd1 << idx);
      check("rsp_m", 32'(int'($signed(rsp_m))), 32'(m_exp));
      check("mult_en_drop", 32'(mult_en), 32'd0);
      handshake(idx);
   endtask

   initial begin
      int en0;
      rst_n     = 1'b0;
      rsp_ready = 4'd0;
      req_valid = 4'd0;
      req_a     = 32'd0;
      req_b     = 32'd0;
      // Contention operands held from reset: 15, -24, -100, 18.
      set_req(0, 8'h03, 8'h05);
      set_req(1, 8'hFC, 8'h06);
      set_req(2, 8'h0A, 8'hF6);
      set_req(3, 8'hFE, 8'hF7);
      repeat (3) @(negedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_m", 32'(rsp_m), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mult_en", 32'(mult_en), 32'd0);
      check("rst_mult_ab", {16'd0, mult_a, mult_b}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      serve(0, 8'h03, 8'h05, 15, 1'b1);
      serve(1, 8'hFC, 8'h06, -24, 1'b1);
      serve(2, 8'h0A, 8'hF6, -100, 1'b1);
      serve(3, 8'hFE, 8'hF7, 18, 1'b1);
      serve(0, 8'h03, 8'h05, 15, 1'b0);

      set_req(1, 8'hF9, 8'h0C);
      serve(1, 8'hF9, 8'h0C, -84, 1'b0);

      // Backpressure on requester 2 while requester 0 waits.
      set_req(2, 8'h7F, 8'h80);
      wait_grant();
      check("bp_grant", 32'(req_ready), 32'd4);
      @(negedge clk);
      req_valid = 4'd0;
      set_req(0, 8'hFF, 8'h01);
      wait_rsp();
      check("bp_rsp_m", 32'(int'($signed(rsp_m))), 32'(-16256));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         check("bp_hold_m", 32'(int'($signed(rsp_m))), 32'(-16256));
         check("bp_hold_valid", 32'(rsp_valid), 32'd4);
         check("bp_no_grant", 32'(req_ready), 32'd0);
      end
      handshake(2);
      serve(0, 8'hFF, 8'h01, -1, 1'b0);

      set_req(3, 8'h80, 8'h80);
      serve(3, 8'h80, 8'h80, 16384, 1'b0);
      set_req(1, 8'h7F, 8'h7F);
      serve(1, 8'h7F, 8'h7F, 16129, 1'b0);

      // Reset while the multiplier is running.
      set_req(1, 8'h05, 8'hFD);
      wait_grant();
      @(negedge clk);
      req_valid = 4'd0;
      check("mid_en_before", 32'(mult_en), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_en_after", 32'(mult_en), 32'd0);
      check("mid_busy_after", 32'(busy), 32'd0);
      check("mid_grant_after", 32'(grant_id), 32'd0);
      check("mid_rsp_after", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      en0 = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rsp_valid != 4'd0) en0++;
      end
      check("mid_no_rsp", 32'(en0), 32'd0);
      set_req(2, 8'hFA, 8'hF9);
      serve(2, 8'hFA, 8'hF9, 42, 1'b0);

      // Zero operand.
      set_req(0, 8'h00, 8'h37);
`ifdef MULT_ZERO_BYPASS_EN
      wait_grant();
      check("zero_grant", 32'(req_ready), 32'd1);
      en0 = en_cycles_r;
      @(negedge clk);
      req_valid = 4'd0;
      check("zero_rsp_valid", 32'(rsp_valid), 32'd1);
      check("zero_rsp_m", 32'(rsp_m), 32'd0);
      check("zero_mult_en", 32'(mult_en), 32'd0);
      handshake(0);
      check("zero_no_mult", 32'(en_cycles_r - en0), 32'd0);
`else
      en0 = en_cycles_r;
      serve(0, 8'h00, 8'h37, 0, 1'b0);
      check("zero_used_mult", 32'(en_cycles_r - en0 > 0), 32'd1);
`endif
      check("onehot_monitor", 32'(multi_hot_r), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
      $finish;
   end

endmodule
